dffram_banked: RTL and testbench
================================

Name: dffram_banked

Overview:
- Single-port, byte-write-enabled RAM built from standard cells: flip-flops, or latches when USE_LATCH=1.
- Organised as BANKS banks of 16 words, each word WSIZE bytes wide.
- One synchronous read/write port.
- Used as a small scratchpad or register-file memory inside an SoC subsystem.

Parameters:
- USE_LATCH, 1, 1 = latch-based storage cells; 0 = flip-flop storage. Cycle-level function is identical for both.
- WSIZE, 4, word width in bytes. Data width is 8*WSIZE bits.
- BANKS, 2, number of 16-word banks. Must be a power of two and ≥1. Depth is 16*BANKS words.
- Derived constant AWIDTH = $clog2(BANKS)+4 (5 at defaults).

Ports:
- CLK  input  1  clock; all sampling on rising edge.
- RST  input  1  asynchronous, active-high reset.
- EN0  input  1  port enable; no read or write when low.
- WE0  input  WSIZE  per-byte write enable; bit i controls Di0[8i+7:8i].
- A0   input  AWIDTH  word address. Upper $clog2(BANKS) bits select the bank; lower 4 bits select the word within the bank.
- Di0  input  8*WSIZE  write data.
- Do0  output 8*WSIZE  registered read data.

Behaviour:
- Reset:
  - RST high asynchronously forces Do0 to 0 and holds it at 0 while asserted.
  - Memory contents are not cleared by reset; they are undefined until written.
  - No write occurs on any edge where RST is high.
- Write:
  - At posedge CLK with EN0=1 and RST=0, each byte i with WE0[i]=1 stores Di0 byte i into word A0.
  - Bytes with WE0[i]=0 keep their old value.
- Read:
  - At posedge CLK with EN0=1 and RST=0, Do0 is loaded with word A0. This happens whether or not any WE0 bit is set.
  - Latency is one cycle: Do0 is valid after the edge that sampled A0.
- Read-during-write to the same address: Do0 returns the pre-write (old) contents (read-first). The new data is visible on a read sampled at the next edge or later.
- EN0=0: memory and Do0 both hold.
- Write mask all zero with EN0=1: behaves as a pure read.
- Address decode:
  - Exactly one bank and one word are selected per access. All A0 values are legal.
- Latch mode (USE_LATCH=1):
  - Each word's byte-lanes use clock-gated latches, enabled during CLK low after the write edge, fed from a registered copy of Di0.
  - The observable result must match flip-flop mode at every rising edge, including read-first behaviour.
- The output mux selects the bank from the registered bank index, so Do0 changes only at clock edges.

Decomposition:
- Shared package dffram_pkg:
  - function computing AWIDTH from BANKS.
  - constants WORDS_PER_BANK=16 and BYTE_W=8.
- Natural sub-module dffram_bank16:
  - one 16-word bank with byte write enables, a word decoder, and generate-selected latch or flip-flop storage.
  - Instantiated BANKS times by the top level, which does bank decode and the output mux/register.

Test Plan:
- Full writes then read:
  - Write 0xAA0055BB to addr 0, 0xAA0055CC to addr 1, 0xAA0055DD to addr 2, each with WE0=1111.
  - Read addr 0 → Do0=0xAA0055BB one cycle after the address is sampled.
- Byte-masked writes over the above contents:
  - Write 0x00000033 to addr 2 with WE0=0001 → addr 2 reads 0xAA005533.
  - Write 0x00003300 to addr 1 with WE0=0010 → addr 1 reads 0xAA0033CC.
  - Write 0x00330000 to addr 0 with WE0=0100 → addr 0 reads 0xAA3355BB.
- Bank boundary:
  - Write 0x11111111 to addr 15 and 0x22222222 to addr 16.
  - Reads return those values, and addr 0 is unchanged.
- Read-first:
  - Addr 3 holds 0x01020304.
  - Write 0xDEADBEEF to addr 3 with WE0=1111 → Do0=0x01020304 after that edge.
  - Next read of addr 3 → 0xDEADBEEF.
- Enable low:
  - EN0=0 with WE0=1111, A0=0, Di0=0xFFFFFFFF → addr 0 is unchanged and Do0 holds its prior value.
- Reset:
  - Assert RST mid-read, between clock edges → Do0 becomes 0 immediately.
  - A write attempted while RST=1 has no effect.
  - After RST deasserts, earlier written data reads back intact.
- Repeat all scenarios for USE_LATCH=0 and USE_LATCH=1 with identical expected values.

Source files
------------

// File: rtl/dffram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dffram_pkg
// Purpose  : Shared constants and helpers for the banked standard-cell RAM.
// Revision : 1.0 - initial release
// ============================================================================
package dffram_pkg;

    localparam int WORDS_PER_BANK = 16;
    localparam int BYTE_W         = 8;

    // Address width: 4 bits of word-in-bank plus enough bits to pick a bank.
    function automatic int calc_awidth(input int banks);
        return ((banks > 1) ? $clog2(banks) : 0) + 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dffram_bank16.sv
`default_nettype none
// ============================================================================
// Module   : dffram_bank16
// Purpose  : One 16-word bank with byte write enables, a word decoder,
//            latch or flip-flop storage, and a registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module dffram_bank16
    import dffram_pkg::*;
#(
    parameter  int USE_LATCH = 1,
    parameter  int WSIZE     = 4,
    localparam int DW        = BYTE_W * WSIZE
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SEL,
    input  logic [WSIZE-1:0] WE,
    input  logic [3:0]       A,
    input  logic [DW-1:0]    Di,
    output logic [DW-1:0]    Do
);

    logic [WORDS_PER_BANK-1:0]            w_dec;
    logic [WORDS_PER_BANK-1:0][WSIZE-1:0] w_wen;
    logic [WORDS_PER_BANK-1:0][DW-1:0]    w_cells;
    logic [DW-1:0]                        r_do;

    // Word decoder and per-lane write enables (only when this bank is selected)
    always_comb begin
        w_dec    = '0;
        w_dec[A] = SEL;
        for (int w = 0; w < WORDS_PER_BANK; w++) begin
            for (int b = 0; b < WSIZE; b++) begin
                w_wen[w][b] = w_dec[w] & WE[b];
            end
        end
    end

    generate
        if (USE_LATCH != 0) begin : g_latch
            logic [DW-1:0]                        r_di;
            logic [WORDS_PER_BANK-1:0][WSIZE-1:0] r_wen;

            // Capture write data and lane enables at the write edge; a reset
            // present at that edge cancels the write.
            always_ff @(posedge CLK) begin
                r_di  <= Di;
                r_wen <= RST ? '0 : w_wen;
            end

            for (genvar w = 0; w < WORDS_PER_BANK; w++) begin : g_word
                for (genvar b = 0; b < WSIZE; b++) begin : g_byte
                    logic              w_gate;
                    logic [BYTE_W-1:0] r_lat;

                    // Gate opens only in the low phase after the write edge, so
                    // a read sampled on that edge still sees the old byte.
                    assign w_gate = ~CLK & r_wen[w][b];

                    // Transparent storage latch for one byte lane
                    always_latch begin
                        if (w_gate) r_lat = r_di[b*BYTE_W +: BYTE_W];
                    end

                    assign w_cells[w][b*BYTE_W +: BYTE_W] = r_lat;
                end
            end
        end else begin : g_ff
            for (genvar w = 0; w < WORDS_PER_BANK; w++) begin : g_word
                logic [DW-1:0] r_word;

                // Edge-triggered byte-lane writes; contents are never cleared
                always_ff @(posedge CLK) begin
                    if (!RST) begin
                        for (int b = 0; b < WSIZE; b++) begin
                            if (w_wen[w][b]) r_word[b*BYTE_W +: BYTE_W] <= Di[b*BYTE_W +: BYTE_W];
                        end
                    end
                end

                assign w_cells[w] = r_word;
            end
        end
    endgenerate

    // Registered read of the addressed word; it samples pre-write contents
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)      r_do <= '0;
        else if (SEL) r_do <= w_cells[A];
    end

    assign Do = r_do;

endmodule
`default_nettype wire

// File: rtl/dffram_banked.sv
`default_nettype none
// ============================================================================
// Module   : dffram_banked
// Purpose  : Single-port byte-writable RAM of BANKS x 16 words, built from
//            standard-cell storage; one-cycle registered read, read-first.
// Revision : 1.0 - initial release
// ============================================================================
module dffram_banked
    import dffram_pkg::*;
#(
    parameter  int USE_LATCH = 1,
    parameter  int WSIZE     = 4,
    parameter  int BANKS     = 2,
    localparam int AWIDTH    = calc_awidth(BANKS),
    localparam int DW        = BYTE_W * WSIZE
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN0,
    input  logic [WSIZE-1:0]  WE0,
    input  logic [AWIDTH-1:0] A0,
    input  logic [DW-1:0]     Di0,
    output logic [DW-1:0]     Do0
);

    localparam int c_BW = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic [c_BW-1:0]            w_bank;
    logic [c_BW-1:0]            r_bank;
    logic [BANKS-1:0]           w_sel;
    logic [BANKS-1:0][DW-1:0]   w_bank_do;

    generate
        if (BANKS > 1) begin : g_bank_idx
            assign w_bank = A0[AWIDTH-1:4];
        end else begin : g_bank_idx_single
            assign w_bank = '0;
        end
    endgenerate

    // Bank decode: exactly one bank is selected whenever the port is enabled
    always_comb begin
        for (int i = 0; i < BANKS; i++) begin
            w_sel[i] = EN0 && (w_bank == c_BW'(i));
        end
    end

    generate
        for (genvar i = 0; i < BANKS; i++) begin : g_bank
            dffram_bank16 #(
                .USE_LATCH (USE_LATCH),
                .WSIZE     (WSIZE)
            ) u_bank (
                .CLK (CLK),
                .RST (RST),
                .SEL (w_sel[i]),
                .WE  (WE0),
                .A   (A0[3:0]),
                .Di  (Di0),
                .Do  (w_bank_do[i])
            );
        end
    endgenerate

    // Remember which bank produced the current read so the mux is edge-stable
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)      r_bank <= '0;
        else if (EN0) r_bank <= w_bank;
    end

    assign Do0 = w_bank_do[r_bank];

endmodule
`default_nettype wire

// File: tb/tb_dffram_banked.sv
`default_nettype none
// ============================================================================
// Module   : tb_dffram_banked
// Purpose  : Self-checking bench; drives flip-flop and latch variants with the
//            same stimulus and compares both against a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dffram_banked;

    localparam int DEPTH = 32;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN0 = 1'b0;
    logic [3:0]  WE0 = '0;
    logic [4:0]  A0  = '0;
    logic [31:0] Di0 = '0;
    logic [31:0] do_ff;
    logic [31:0] do_lat;

    int checks = 0;
    int errors = 0;

    // Behavioural memory: value plus which bytes have ever been written
    logic [31:0] m_mem   [DEPTH];
    logic [3:0]  m_known [DEPTH];
    logic [31:0] exp_do = '0;
    logic [3:0]  exp_kn = 4'hF;
    bit          run    = 1'b0;

    always #5 CLK = ~CLK;

    dffram_banked #(.USE_LATCH(0), .WSIZE(4), .BANKS(2)) u_dut_ff (
        .CLK (CLK), .RST (RST), .EN0 (EN0), .WE0 (WE0), .A0 (A0), .Di0 (Di0), .Do0 (do_ff)
    );

    dffram_banked #(.USE_LATCH(1), .WSIZE(4), .BANKS(2)) u_dut_lat (
        .CLK (CLK), .RST (RST), .EN0 (EN0), .WE0 (WE0), .A0 (A0), .Di0 (Di0), .Do0 (do_lat)
    );

    function automatic logic [31:0] lane_mask(input logic [3:0] k);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{k[b]}};
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on every falling edge
    always @(negedge CLK) begin
        if (run) begin
            check("model_ff",  do_ff  & lane_mask(exp_kn), exp_do & lane_mask(exp_kn));
            check("model_lat", do_lat & lane_mask(exp_kn), exp_do & lane_mask(exp_kn));
        end
    end

    // One port cycle: drive at the falling edge, optionally raise reset
    // mid-cycle, then update the model with what the rising edge must do.
    task automatic op(input bit en, input logic [3:0] we, input int a,
                      input logic [31:0] di, input bit rst_mid);
        EN0 = en;
        WE0 = we;
        A0  = a[4:0];
        Di0 = di;
        if (rst_mid) begin
            #2;
            RST    = 1'b1;
            exp_do = '0;
            exp_kn = 4'hF;
        end
        @(posedge CLK);
        if (RST) begin
            exp_do = '0;
            exp_kn = 4'hF;
        end else if (en) begin
            exp_do = m_mem[a];
            exp_kn = m_known[a];
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    m_mem[a][b*8 +: 8] = di[b*8 +: 8];
                    m_known[a][b]      = 1'b1;
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic wr(input int a, input logic [3:0] we, input logic [31:0] di);
        op(1'b1, we, a, di, 1'b0);
    endtask

    // Read with a hand-computed expectation for both variants
    task automatic rd(input int a, input logic [31:0] lit, input string name);
        op(1'b1, 4'h0, a, $urandom, 1'b0);
        check({name, "_ff"},  do_ff,  lit);
        check({name, "_lat"}, do_lat, lit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = '0;
            m_known[i] = '0;
        end

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_ff",  do_ff,  32'h0);
        check("reset_lat", do_lat, 32'h0);
        run = 1'b1;
        RST = 1'b0;

        // Full writes then read
        wr(0, 4'hF, 32'hAA0055BB);
        wr(1, 4'hF, 32'hAA0055CC);
        wr(2, 4'hF, 32'hAA0055DD);
        rd(0, 32'hAA0055BB, "full_rd0");

        // Byte-masked writes
        wr(2, 4'b0001, 32'h00000033);
        wr(1, 4'b0010, 32'h00003300);
        wr(0, 4'b0100, 32'h00330000);
        rd(2, 32'hAA005533, "mask_rd2");
        rd(1, 32'hAA0033CC, "mask_rd1");
        rd(0, 32'hAA3355BB, "mask_rd0");

        // Bank boundary
        wr(15, 4'hF, 32'h11111111);
        wr(16, 4'hF, 32'h22222222);
        rd(15, 32'h11111111, "bound_rd15");
        rd(16, 32'h22222222, "bound_rd16");
        rd(0,  32'hAA3355BB, "bound_rd0");

        // Read-first on same-address write
        wr(3, 4'hF, 32'h01020304);
        wr(3, 4'hF, 32'hDEADBEEF);
        check("rdfirst_ff",  do_ff,  32'h01020304);
        check("rdfirst_lat", do_lat, 32'h01020304);
        rd(3, 32'hDEADBEEF, "rdfirst_new");

        // Enable low: nothing changes
        op(1'b0, 4'hF, 0, 32'hFFFFFFFF, 1'b0);
        check("en_low_ff",  do_ff,  32'hDEADBEEF);
        check("en_low_lat", do_lat, 32'hDEADBEEF);
        rd(0, 32'hAA3355BB, "en_low_rd0");

        // Asynchronous reset mid-read, write blocked during reset
        rd(16, 32'h22222222, "pre_rst_rd16");
        #2;
        RST    = 1'b1;
        exp_do = '0;
        exp_kn = 4'hF;
        #1;
        check("rst_async_ff",  do_ff,  32'h0);
        check("rst_async_lat", do_lat, 32'h0);
        op(1'b1, 4'hF, 0, 32'hFFFFFFFF, 1'b0);
        check("rst_hold_ff",  do_ff,  32'h0);
        check("rst_hold_lat", do_lat, 32'h0);
        RST = 1'b0;
        rd(0,  32'hAA3355BB, "post_rst_rd0");
        rd(16, 32'h22222222, "post_rst_rd16");
        rd(3,  32'hDEADBEEF, "post_rst_rd3");

        // Randomized traffic, checked by the model each cycle
        for (int i = 0; i < 400; i++) begin
            if (RST) RST = 1'b0;
            op($urandom_range(0, 9) != 0,
               4'($urandom),
               int'($urandom_range(0, DEPTH - 1)),
               $urandom,
               $urandom_range(0, 39) == 0);
        end
        RST = 1'b0;
        op(1'b0, 4'h0, 0, 32'h0, 1'b0);

        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
